lsu_data_mem: RTL and testbench

LSU_DATA_MEM -- requirements
Module: lsu_data_mem

---
 rtl/lsu_data_mem.sv | 174 +++++++++++++++++
 tb/tb_lsu_data_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_mem.sv
// Single-port data memory for a load/store unit: one request in flight, fixed response latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module lsu_data_mem #(
   parameter int unsigned DEPTH_WORDS = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [2:0]          r_funct3;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;
   logic [31:0]         r_mem [DEPTH_WORDS];

   logic [IDX_W-1:0]    w_idx;
   logic [1:0]          w_lo;
   logic [31:0]         w_word;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic                w_oor;
   logic                w_bad_f3;
   logic                w_misalign;
   logic                w_err;
   logic [31:0]         w_load;
   logic [31:0]         w_store;
   logic                w_access;
   logic                w_mem_we;

   assign w_idx  = r_addr[IDX_W+1:2];
   assign w_lo   = r_addr[1:0];
   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[8*w_lo +: 8];
   assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
   assign w_oor  = (r_addr >> (IDX_W + 2)) != '0;

   // Legal width codes differ between loads and stores
   always_comb begin
      w_bad_f3 = 1'b1;
      if (r_we) begin
         w_bad_f3 = (r_funct3 > 3'b010);
      end else begin
         case (r_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_bad_f3 = 1'b0;
            default:                                w_bad_f3 = 1'b1;
         endcase
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                       ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_err = w_oor || w_bad_f3 || w_misalign;

   always_comb begin
      w_load = '0;
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b010:  w_load = w_word;
         3'b100:  w_load = {24'h0, w_byte};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = '0;
      endcase
   end

   // Read-modify-write merge: only the addressed lanes take store data
   always_comb begin
      w_store = w_word;
      case (r_funct3[1:0])
         2'b00: w_store[8*w_lo +: 8] = r_wdata[7:0];
         2'b01: begin
            if (r_addr[1]) w_store[31:16] = r_wdata[15:0];
            else           w_store[15:0]  = r_wdata[15:0];
         end
         default: w_store = r_wdata;
      endcase
   end

   assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
   assign w_mem_we = w_access && r_we && !w_err && !reset;

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_idx] <= w_store;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_funct3    <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_funct3    <= req_funct3;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_cnt       <= CNT_W'(LATENCY - 1);
                  r_req_ready <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_load;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench for lsu_data_mem: directed cases plus random traffic against a byte-array model.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_data_mem;

   localparam int unsigned DEPTH   = 32;
   localparam int unsigned AW      = 32;
   localparam int unsigned LAT     = 2;
   localparam int unsigned NBYTES  = DEPTH * 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] tb_mem [NBYTES];

   lsu_data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: memory as bytes, access size 1/2/4 from the width code
   function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit err);
      int unsigned size;
      int unsigned base;
      bit          legal;
      logic [31:0] val;
      rd  = 32'h0;
      err = 1'b0;
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      size = 1 << f3[1:0];
      if (!legal || addr >= NBYTES) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (legal && (addr % size) != 0) err = 1'b1;
`endif
      if (err) return;
      base = addr - (addr % size);
      if (we) begin
         for (int i = 0; i < int'(size); i++) tb_mem[base + i] = wd[8*i +: 8];
      end else begin
         val = 32'h0;
         for (int i = 0; i < int'(size); i++) val = val | (32'(tb_mem[base + i]) << (8*i));
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'h1 << (8*size)) - 32'h1);
         rd = val;
      end
   endfunction

   task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      chk("req_ready_idle", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid  = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input logic [31:0] exp_rd, input bit exp_err);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(LAT));
      chk({tag, "_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
   endtask

   task automatic release_rsp(input int stall);
      for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", 32'(rsp_valid), 32'h0);
      chk("req_ready_back", 32'(req_ready), 32'h1);
   endtask

   // Directed transaction with an explicit expected value; the model is kept in step
   task automatic txn_exp(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
      logic [31:0] m_rd;
      bit          m_err;
      model(we, f3, addr, wd, m_rd, m_err);
      issue(we, f3, addr, wd);
      wait_rsp(tag, exp_rd, exp_err);
      release_rsp(0);
   endtask

   initial begin
      logic [31:0] a_rd, b_rd, hold_rd;
      bit          a_err, b_err, rerr;
      logic        hold_err;
      bit          rwe;
      logic [2:0]  rf3;
      logic [31:0] raddr, rwd, rrd;

      for (int i = 0; i < int'(NBYTES); i++) tb_mem[i] = 8'h0;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Sign/zero extension from one stored word
      txn_exp("sw10",  1'b1, 3'b010, 32'h10, 32'h800000FF, 32'h0, 1'b0);
      txn_exp("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0);
      txn_exp("lbu10", 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000FF, 1'b0);
      txn_exp("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8000, 1'b0);
      txn_exp("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h800000FF, 1'b0);

      // Partial stores preserve other lanes
      txn_exp("sw14",  1'b1, 3'b010, 32'h14, 32'h0, 32'h0, 1'b0);
      txn_exp("sb15",  1'b1, 3'b000, 32'h15, 32'h123456AB, 32'h0, 1'b0);
      txn_exp("sh16",  1'b1, 3'b001, 32'h16, 32'h0000BEEF, 32'h0, 1'b0);
      txn_exp("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 32'hBEEFAB00, 1'b0);

      // Back-pressure: response held, second request waits
      model(1'b0, 3'b010, 32'h10, 32'h0, a_rd, a_err);
      model(1'b0, 3'b100, 32'h14, 32'h0, b_rd, b_err);
      issue(1'b0, 3'b010, 32'h10, 32'h0);
      wait_rsp("bp_a", 32'h800000FF, 1'b0);
      hold_rd  = rsp_rdata;
      hold_err = rsp_err;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h14; req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_valid_hold", 32'(rsp_valid), 32'h1);
         chk("bp_rdata_hold", rsp_rdata, hold_rd);
         chk("bp_err_hold", 32'(rsp_err), 32'(hold_err));
         chk("bp_not_ready", 32'(req_ready), 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_valid_drop", 32'(rsp_valid), 32'h0);
      chk("bp_ready_back", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_b_accepted", 32'(req_ready), 32'h0);
      wait_rsp("bp_b", 32'h00000000, 1'b0);
      release_rsp(0);

      // Out-of-range and illegal width codes
      txn_exp("lw80",  1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1'b1);
      txn_exp("sw80",  1'b1, 3'b010, 32'h80, 32'hFFFFFFFF, 32'h0, 1'b1);
      txn_exp("lw00",  1'b0, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0);
      txn_exp("ld011", 1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 1'b1);
      txn_exp("st011", 1'b1, 3'b011, 32'h04, 32'h55555555, 32'h0, 1'b1);
      txn_exp("lw04",  1'b0, 3'b010, 32'h04, 32'h0, 32'h0, 1'b0);

      // Reset during WAIT discards the pending store
      txn_exp("sw20",  1'b1, 3'b010, 32'h20, 32'h5A5A5A5A, 32'h0, 1'b0);
      issue(1'b1, 3'b010, 32'h20, 32'h11111111);
      reset = 1'b1;
      #3;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("wait_rst_ready", 32'(req_ready), 32'h1);
      chk("wait_rst_valid", 32'(rsp_valid), 32'h0);
      @(posedge clk); #1;
      txn_exp("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h5A5A5A5A, 1'b0);

      // Reset mid-cycle while a response is presented acts without a clock edge
      issue(1'b0, 3'b010, 32'h14, 32'h0);
      wait_rsp("pre_rst", 32'hBEEFAB00, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("async_req_ready", 32'(req_ready), 32'h1);
      chk("async_rdata", rsp_rdata, 32'h0);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Misaligned word load
      txn_exp("swcafe", 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
      txn_exp("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
`else
      txn_exp("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'hCAFEF00D, 1'b0);
`endif

      // Random traffic against the model
      for (int k = 0; k < 80; k++) begin
         rwe   = 1'($urandom_range(0, 1));
         rf3   = 3'($urandom_range(0, 7));
         raddr = 32'($urandom_range(0, 159));
         rwd   = $urandom;
         model(rwe, rf3, raddr, rwd, rrd, rerr);
         issue(rwe, rf3, raddr, rwd);
         wait_rsp("rnd", rrd, rerr);
         release_rsp(int'($urandom_range(0, 2)));
      end

      // Final sweep: every word read back matches the model
      for (int w = 0; w < int'(DEPTH); w++) begin
         model(1'b0, 3'b010, 32'(w * 4), 32'h0, rrd, rerr);
         issue(1'b0, 3'b010, 32'(w * 4), 32'h0);
         wait_rsp("sweep", rrd, rerr);
         release_rsp(0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
